// File: rtl/pool_window_fetcher.sv
// -----------------------------------------------------------------------------
// pool_window_fetcher
//
// Walks a square IMG_W x IMG_W layer-0 feature map in 2x2 windows, raster
// order. For each window it issues four reads, collects the samples into a
// registered quad and presents the quad, with its pooled index, to the
// downstream four-input max comparator through a valid/ready handshake.
//
// Per-window sequence: FETCH (4 reads) -> CAPT (last sample lands) ->
// PRESENT (wait for win_ready). This gives 6 cycles per window when the
// consumer is always ready. FIN pulses done once after the final window.
//
// Optional build macro:
//   POOL_RELU_EN  - when defined, each sample is clamped at zero (ReLU) as it
//                   is captured. Timing and handshake are unchanged.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request to pool the whole map (ignored unless idle)
//   busy       high while a map is being processed
//   done       one-cycle pulse after the last window handshake
//   mem_rd     layer-0 read strobe
//   mem_addr   layer-0 read address (0 when not reading)
//   mem_rdata  signed read data, valid one cycle after mem_rd
//   win_valid  window quad valid
//   win_ready  consumer accepts the quad
//   win_a..d   samples at (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1)
//   win_idx    pooled index r*(IMG_W/2)+c
// -----------------------------------------------------------------------------
module pool_window_fetcher #(
    parameter int DATA_WIDTH = 20,
    parameter int IMG_W      = 64,
    parameter int ADDR_WIDTH = 12,
    parameter int IDX_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         mem_rd,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic signed [DATA_WIDTH-1:0] mem_rdata,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic signed [DATA_WIDTH-1:0] win_a,
    output logic signed [DATA_WIDTH-1:0] win_b,
    output logic signed [DATA_WIDTH-1:0] win_c,
    output logic signed [DATA_WIDTH-1:0] win_d,
    output logic [IDX_WIDTH-1:0]         win_idx
);

    localparam int HALF = IMG_W / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [ADDR_WIDTH-1:0] PIX_ROW = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] WIN_ROW = ADDR_WIDTH'(2 * IMG_W);
    localparam logic [IDX_WIDTH-1:0]  IDX_ROW = IDX_WIDTH'(HALF);
    localparam logic [CW-1:0]         LAST_RC = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPT,
        S_PRESENT,
        S_FIN
    } state_t;

    state_t                        state_reg, state_next;
    logic [1:0]                    k_reg, k_next;
    logic [CW-1:0]                 r_reg, r_next;
    logic [CW-1:0]                 c_reg, c_next;
    logic [3:0]                    capt_en;
    logic signed [DATA_WIDTH-1:0]  capt_value;
    logic [ADDR_WIDTH-1:0]         base_addr;
    logic [ADDR_WIDTH-1:0]         addr_off;
    logic                          last_col;
    logic                          last_win;

    // ------------------------------------------------------------------
    // State and window-position registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            k_reg     <= 2'd0;
            r_reg     <= '0;
            c_reg     <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            r_reg     <= r_next;
            c_reg     <= c_next;
        end
    end

    assign last_col = (c_reg == LAST_RC);
    assign last_win = last_col && (r_reg == LAST_RC);

    // ------------------------------------------------------------------
    // Next-state logic and sample-slot capture enables
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        capt_en    = 4'b0000;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    k_next     = 2'd0;
                    r_next     = '0;
                    c_next     = '0;
                end
            end
            S_FETCH: begin
                k_next = k_reg + 2'd1;
                // Read data trails the strobe by one cycle, so read k-1 is
                // landing while read k is being issued.
                if (k_reg != 2'd0) capt_en[k_reg - 2'd1] = 1'b1;
                if (k_reg == 2'd3) state_next = S_CAPT;
            end
            S_CAPT: begin
                capt_en[3] = 1'b1;
                state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (win_ready) begin
                    if (last_win) begin
                        state_next = S_FIN;
                    end else begin
                        state_next = S_FETCH;
                        k_next     = 2'd0;
                        if (last_col) begin
                            c_next = '0;
                            r_next = r_reg + 1'b1;
                        end else begin
                            c_next = c_reg + 1'b1;
                        end
                    end
                end
            end
            S_FIN: begin
                // Park the position at the origin so an idle block shows idx 0.
                state_next = S_IDLE;
                r_next     = '0;
                c_next     = '0;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Read address generation: base = 2r*IMG_W + 2c
    // ------------------------------------------------------------------
    assign base_addr = ADDR_WIDTH'(r_reg) * WIN_ROW + (ADDR_WIDTH'(c_reg) << 1);

    always_comb begin
        addr_off = '0;
        case (k_reg)
            2'd0: addr_off = '0;
            2'd1: addr_off = ADDR_WIDTH'(1);
            2'd2: addr_off = PIX_ROW;
            2'd3: addr_off = PIX_ROW + ADDR_WIDTH'(1);
            default: addr_off = '0;
        endcase
    end

    assign mem_rd   = (state_reg == S_FETCH);
    assign mem_addr = mem_rd ? (base_addr + addr_off) : '0;

    // ------------------------------------------------------------------
    // Sample conditioning at capture
    // ------------------------------------------------------------------
`ifdef POOL_RELU_EN
    assign capt_value = mem_rdata[DATA_WIDTH-1] ? '0 : mem_rdata;
`else
    assign capt_value = mem_rdata;
`endif

    // ------------------------------------------------------------------
    // Quad sample slots a, b, c, d
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            logic signed [DATA_WIDTH-1:0] slot_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (capt_en[gi]) begin
                    slot_reg <= capt_value;
                end
            end
        end
    endgenerate

    assign win_a = g_slot[0].slot_reg;
    assign win_b = g_slot[1].slot_reg;
    assign win_c = g_slot[2].slot_reg;
    assign win_d = g_slot[3].slot_reg;

    // ------------------------------------------------------------------
    // Status and handshake outputs
    // ------------------------------------------------------------------
    assign win_valid = (state_reg == S_PRESENT);
    assign win_idx   = IDX_WIDTH'(r_reg) * IDX_ROW + IDX_WIDTH'(c_reg);
    assign busy      = (state_reg == S_FETCH) || (state_reg == S_CAPT) ||
                       (state_reg == S_PRESENT);
    assign done      = (state_reg == S_FIN);

endmodule

// File: tb/tb_pool_window_fetcher.sv
// -----------------------------------------------------------------------------
// tb_pool_window_fetcher
//
// Directed bench for pool_window_fetcher with IMG_W=64. The memory model
// returns data equal to the address (or a small signed pattern for the ReLU
// scenario). All bench activity happens on the falling clock edge: outputs
// are snapshotted first, then inputs for the current cycle are driven.
// -----------------------------------------------------------------------------
module tb_pool_window_fetcher;

    localparam int DW = 20;
    localparam int IW = 64;
    localparam int AW = 12;
    localparam int XW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 mem_rd;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] mem_rdata = '0;
    logic                 win_valid;
    logic                 win_ready;
    logic signed [DW-1:0] win_a, win_b, win_c, win_d;
    logic [XW-1:0]        win_idx;

    always #5 clk = ~clk;

    pool_window_fetcher #(
        .DATA_WIDTH(DW),
        .IMG_W     (IW),
        .ADDR_WIDTH(AW),
        .IDX_WIDTH (XW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .mem_rd   (mem_rd),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_a    (win_a),
        .win_b    (win_b),
        .win_c    (win_c),
        .win_d    (win_d),
        .win_idx  (win_idx)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: one-cycle read latency.
    bit pat = 1'b0;

    function automatic logic signed [DW-1:0] mem_model(input logic [AW-1:0] addr);
        if (pat) begin
            case (addr)
                12'd0:  return -20'sd3;
                12'd1:  return 20'sd5;
                12'd64: return -20'sd1;
                12'd65: return 20'sd0;
                default: ;
            endcase
        end
        return DW'(addr);
    endfunction

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_model(mem_addr);
    end

    int checks   = 0;
    int failures = 0;

    // Snapshot of DUT outputs for the current cycle
    int                   s_cyc;
    logic                 s_valid, s_busy, s_done, s_rd;
    logic [AW-1:0]        s_addr;
    logic signed [DW-1:0] s_a, s_b, s_c, s_d;
    logic [XW-1:0]        s_idx;

    // Quads accepted during the full run, in handshake order
    logic signed [DW-1:0] qa [1024];
    logic signed [DW-1:0] qb [1024];
    logic signed [DW-1:0] qc [1024];
    logic signed [DW-1:0] qd [1024];
    logic [XW-1:0]        qi [1024];

    task automatic tick();
        @(negedge clk);
        s_cyc   = cyc;
        s_valid = win_valid;
        s_busy  = busy;
        s_done  = done;
        s_rd    = mem_rd;
        s_addr  = mem_addr;
        s_a     = win_a;
        s_b     = win_b;
        s_c     = win_c;
        s_d     = win_d;
        s_idx   = win_idx;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; win_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_busy, s_done, s_rd, s_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {s_busy, s_done, s_rd, s_valid});
        end
        checks++;
        if (s_addr !== '0 || s_idx !== '0) begin
            failures++;
            $display("FAIL reset_addr_idx got addr=%0d idx=%0d exp 0/0", s_addr, s_idx);
        end
        checks++;
        if (s_a !== 0 || s_b !== 0 || s_c !== 0 || s_d !== 0) begin
            failures++;
            $display("FAIL reset_quad got=%0d,%0d,%0d,%0d exp=0,0,0,0", s_a, s_b, s_c, s_d);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (s_busy !== 1'b0 || s_rd !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b rd=%b exp 0/0", s_busy, s_rd);
        end
        $display("test_reset: done at cycle %0d", s_cyc);
    endtask

    // ------------------------------------------------------------------
    task automatic test_full_run();
        int n;
        int first_valid = -1;
        int hs_n = 0, rd_n = 0, done_n = 0, done_cyc = -1, bad = 0;
        int rd_cyc [8];
        logic [AW-1:0] rd_addr [8];
        logic busy_fetch = 1'b0, busy_at_done = 1'b1, busy_after = 1'b0;

        tick(); win_ready = 1'b1; start = 1'b1; n = s_cyc;
        for (int i = 0; i < 7000 && done_n == 0; i++) begin
            tick(); start = 1'b0;
            if (s_cyc == n + 1) busy_fetch = s_busy;
            if (s_rd) begin
                if (rd_n < 8) begin rd_cyc[rd_n] = s_cyc; rd_addr[rd_n] = s_addr; end
                rd_n++;
            end
            if (s_valid && first_valid < 0) first_valid = s_cyc;
            if (s_valid && win_ready) begin
                if (hs_n < 1024) begin
                    qa[hs_n] = s_a; qb[hs_n] = s_b; qc[hs_n] = s_c; qd[hs_n] = s_d; qi[hs_n] = s_idx;
                end
                hs_n++;
            end
            if (s_done) begin done_n++; done_cyc = s_cyc; busy_at_done = s_busy; end
        end
        checks++;
        if (done_n == 0) begin
            failures++;
            $display("FAIL full_timeout got no done exp done within 7000 cycles");
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (s_done) done_n++;
            if (s_busy) busy_after = 1'b1;
        end

        checks++;
        if (rd_n < 8 || rd_cyc[0] != n + 1 || rd_cyc[3] != n + 4 || rd_cyc[4] != n + 7) begin
            failures++;
            $display("FAIL first_reads_timing got rd0=%0d rd3=%0d rd4=%0d exp %0d/%0d/%0d",
                     rd_cyc[0] - n, rd_cyc[3] - n, rd_cyc[4] - n, 1, 4, 7);
        end
        checks++;
        if (rd_addr[0] !== 0 || rd_addr[1] !== 1 || rd_addr[2] !== 64 || rd_addr[3] !== 65 ||
            rd_addr[4] !== 2 || rd_addr[5] !== 3 || rd_addr[6] !== 66 || rd_addr[7] !== 67) begin
            failures++;
            $display("FAIL first_read_addrs got=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d exp=0,1,64,65,2,3,66,67",
                     rd_addr[0], rd_addr[1], rd_addr[2], rd_addr[3],
                     rd_addr[4], rd_addr[5], rd_addr[6], rd_addr[7]);
        end
        // FETCH x4 then CAPT: the quad is presented six cycles after start.
        checks++;
        if (first_valid != n + 6) begin
            failures++;
            $display("FAIL first_valid_latency got=%0d exp=6", first_valid - n);
        end
        checks++;
        if (busy_fetch !== 1'b1) begin
            failures++;
            $display("FAIL busy_rise got=%b exp=1", busy_fetch);
        end
        checks++;
        if (hs_n != 1024 || rd_n != 4096) begin
            failures++;
            $display("FAIL handshake_count got hs=%0d rd=%0d exp 1024/4096", hs_n, rd_n);
        end
        checks++;
        if (qa[0] !== 0 || qb[0] !== 1 || qc[0] !== 64 || qd[0] !== 65 || qi[0] !== 0) begin
            failures++;
            $display("FAIL quad0 got=%0d,%0d,%0d,%0d idx=%0d exp=0,1,64,65 idx=0",
                     qa[0], qb[0], qc[0], qd[0], qi[0]);
        end
        checks++;
        if (qa[1] !== 2 || qb[1] !== 3 || qc[1] !== 66 || qd[1] !== 67 || qi[1] !== 1) begin
            failures++;
            $display("FAIL quad1 got=%0d,%0d,%0d,%0d idx=%0d exp=2,3,66,67 idx=1",
                     qa[1], qb[1], qc[1], qd[1], qi[1]);
        end
        checks++;
        if (qa[31] !== 62 || qb[31] !== 63 || qc[31] !== 126 || qd[31] !== 127 || qi[31] !== 31) begin
            failures++;
            $display("FAIL quad31 got=%0d,%0d,%0d,%0d idx=%0d exp=62,63,126,127 idx=31",
                     qa[31], qb[31], qc[31], qd[31], qi[31]);
        end
        checks++;
        if (qa[32] !== 128 || qb[32] !== 129 || qc[32] !== 192 || qd[32] !== 193 || qi[32] !== 32) begin
            failures++;
            $display("FAIL quad32 got=%0d,%0d,%0d,%0d idx=%0d exp=128,129,192,193 idx=32",
                     qa[32], qb[32], qc[32], qd[32], qi[32]);
        end
        checks++;
        if (qa[1023] !== 4030 || qb[1023] !== 4031 || qc[1023] !== 4094 || qd[1023] !== 4095 ||
            qi[1023] !== 1023) begin
            failures++;
            $display("FAIL quad1023 got=%0d,%0d,%0d,%0d idx=%0d exp=4030,4031,4094,4095 idx=1023",
                     qa[1023], qb[1023], qc[1023], qd[1023], qi[1023]);
        end
        // Every window against the address formula base = 2r*64 + 2c.
        for (int i = 0; i < 1024; i++) begin
            int r, c, base;
            r = i / 32; c = i % 32; base = 2 * r * IW + 2 * c;
            if (qi[i] !== XW'(i) || qa[i] !== DW'(base) || qb[i] !== DW'(base + 1) ||
                qc[i] !== DW'(base + IW) || qd[i] !== DW'(base + IW + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL all_windows got bad=%0d exp=0", bad);
        end
        // Start cycle and done cycle both counted: (32*32)*6 + 2 = 6146.
        checks++;
        if (done_cyc - n + 1 != 6146) begin
            failures++;
            $display("FAIL total_cycles got=%0d exp=6146", done_cyc - n + 1);
        end
        checks++;
        if (done_n != 1 || busy_at_done !== 1'b0 || busy_after !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got done_n=%0d busy_at_done=%b busy_after=%b exp 1/0/0",
                     done_n, busy_at_done, busy_after);
        end
        $display("test_full_run: handshakes=%0d done_cycle=+%0d", hs_n, done_cyc - n);
    endtask

    // ------------------------------------------------------------------
    // Leaves the DUT in the first FETCH cycle of window 6.
    task automatic test_backpressure();
        int n, hold = 0, hold_start = -1, accept_cyc = -1, next_rd = -1, bad = 0;
        logic [AW-1:0] next_addr = '0;

        tick(); win_ready = 1'b1; start = 1'b1; n = s_cyc;
        for (int i = 0; i < 300 && next_rd < 0; i++) begin
            tick(); start = 1'b0;
            if (s_valid && s_idx == 5 && hold < 7) begin
                if (hold == 0) hold_start = s_cyc;
                if (s_a !== 10 || s_b !== 11 || s_c !== 74 || s_d !== 75 ||
                    s_rd !== 1'b0 || s_busy !== 1'b1) bad++;
                win_ready = 1'b0;
                hold++;
            end else begin
                win_ready = 1'b1;
            end
            if (s_valid && win_ready && s_idx == 5) begin
                accept_cyc = s_cyc;
                if (s_a !== 10 || s_d !== 75) bad++;
            end
            if (s_rd && accept_cyc >= 0 && s_cyc > accept_cyc) begin
                next_rd = s_cyc; next_addr = s_addr;
            end
        end
        checks++;
        if (hold_start != n + 36 || hold != 7) begin
            failures++;
            $display("FAIL bp_window5 got start=+%0d hold=%0d exp +36/7", hold_start - n, hold);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_stable got bad=%0d exp=0", bad);
        end
        checks++;
        if (accept_cyc != hold_start + 7) begin
            failures++;
            $display("FAIL bp_accept got=%0d exp=%0d", accept_cyc - hold_start, 7);
        end
        checks++;
        if (next_rd != accept_cyc + 1 || next_addr !== 12) begin
            failures++;
            $display("FAIL bp_next_fetch got delay=%0d addr=%0d exp 1/12", next_rd - accept_cyc, next_addr);
        end
        $display("test_backpressure: accepted idx5 after %0d stalled cycles", hold);
    endtask

    // ------------------------------------------------------------------
    task automatic test_start_ignored();
        logic got = 1'b0;
        checks++;
        if (s_rd !== 1'b1) begin
            failures++;
            $display("FAIL start_precond got rd=%b exp=1", s_rd);
        end
        start = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            tick(); start = 1'b0; win_ready = 1'b1;
            if (s_valid) got = 1'b1;
        end
        checks++;
        if (!got || s_idx !== 6) begin
            failures++;
            $display("FAIL start_ignored_idx got=%0d exp=6", s_idx);
        end
        checks++;
        if (s_a !== 12 || s_b !== 13 || s_c !== 76 || s_d !== 77) begin
            failures++;
            $display("FAIL start_ignored_quad got=%0d,%0d,%0d,%0d exp=12,13,76,77", s_a, s_b, s_c, s_d);
        end
        $display("test_start_ignored: presented idx=%0d", s_idx);
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset();
        int n;
        logic found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (s_valid && s_idx == 10) begin win_ready = 1'b0; found = 1'b1; end
            else win_ready = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL areset_reach_idx10 got none exp idx 10 presented");
        end
        // Mid low phase, no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_rd, win_valid} !== 4'b0000 || mem_addr !== '0 || win_idx !== '0) begin
            failures++;
            $display("FAIL areset_ctrl got ctrl=%b addr=%0d idx=%0d exp 0000/0/0",
                     {busy, done, mem_rd, win_valid}, mem_addr, win_idx);
        end
        checks++;
        if (win_a !== 0 || win_b !== 0 || win_c !== 0 || win_d !== 0) begin
            failures++;
            $display("FAIL areset_quad got=%0d,%0d,%0d,%0d exp=0,0,0,0", win_a, win_b, win_c, win_d);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick(); start = 1'b1; win_ready = 1'b1; n = s_cyc;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(); start = 1'b0;
            if (s_valid) found = 1'b1;
        end
        checks++;
        if (!found || s_cyc != n + 6) begin
            failures++;
            $display("FAIL restart_latency got=%0d exp=6", s_cyc - n);
        end
        checks++;
        if (s_idx !== 0 || s_a !== 0 || s_b !== 1 || s_c !== 64 || s_d !== 65) begin
            failures++;
            $display("FAIL restart_quad got=%0d,%0d,%0d,%0d idx=%0d exp=0,1,64,65 idx=0",
                     s_a, s_b, s_c, s_d, s_idx);
        end
        $display("test_async_reset: restarted at idx=%0d", s_idx);
    endtask

    // ------------------------------------------------------------------
    task automatic test_relu();
        int ea, eb, ec, ed;
        logic found = 1'b0;
`ifdef POOL_RELU_EN
        ea = 0;  eb = 5; ec = 0;  ed = 0;
`else
        ea = -3; eb = 5; ec = -1; ed = 0;
`endif
        rst_n = 1'b0; pat = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); start = 1'b1; win_ready = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(); start = 1'b0;
            if (s_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL relu_timeout got no valid exp valid");
        end
        checks++;
        if (s_a !== DW'(ea) || s_b !== DW'(eb) || s_c !== DW'(ec) || s_d !== DW'(ed)) begin
            failures++;
            $display("FAIL relu_quad got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d",
                     s_a, s_b, s_c, s_d, ea, eb, ec, ed);
        end
        $display("test_relu: quad=%0d,%0d,%0d,%0d", s_a, s_b, s_c, s_d);
        rst_n = 1'b0; pat = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_start_ignored();
        test_async_reset();
        test_relu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
